// File: rtl/i2c_master_xfer_seq.sv
// I2C transfer sequencer: turns one descriptor into ordered byte-controller commands, with TX/RX byte FIFOs.
// Optional per-command watchdog compiled in with I2C_SEQ_TIMEOUT_EN.
module i2c_master_xfer_seq #(
   parameter int FIFO_AW = 3,
   parameter int LEN_W   = 8,
   parameter int TMO_CYC = 65535
) (
   input  logic             i_sysclk,
   input  logic             i_nReset,
   input  logic             i_enable,
   input  logic             i_go,
   input  logic [6:0]       i_slave_addr,
   input  logic             i_rw,
   input  logic [LEN_W-1:0] i_len,
   input  logic             i_no_stop,
   input  logic             i_tx_wr,
   input  logic [7:0]       i_tx_data,
   output logic             o_tx_full,
   input  logic             i_rx_rd,
   output logic [7:0]       o_rx_data,
   output logic             o_rx_empty,
   output logic             o_cmd_trig,
   output logic [3:0]       o_cmd,
   output logic [7:0]       o_data,
   input  logic             i_cmd_ack,
   input  logic             i_i2c_ack,
   input  logic             i_i2c_al,
   input  logic             i_i2c_busy,
   input  logic [7:0]       i_data,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_nack,
   output logic             o_al,
   output logic             o_held
);
   localparam logic [3:0] CMD_IDLE    = 4'h0;
   localparam logic [3:0] CMD_START   = 4'h1;
   localparam logic [3:0] CMD_RESTART = 4'h2;
   localparam logic [3:0] CMD_STOP    = 4'h3;
   localparam logic [3:0] CMD_WRITE   = 4'h4;
   localparam logic [3:0] CMD_READ    = 4'h5;
   localparam logic [3:0] CMD_RD_ACK  = 4'h6;
   localparam logic [3:0] CMD_WR_ACK  = 4'h7;
   localparam logic [3:0] CMD_WR_NAK  = 4'h8;

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_START    = 4'd1;
   localparam logic [3:0] S_ADDR     = 4'd2;
   localparam logic [3:0] S_ADDR_CHK = 4'd3;
   localparam logic [3:0] S_WR       = 4'd4;
   localparam logic [3:0] S_WR_CHK   = 4'd5;
   localparam logic [3:0] S_RD       = 4'd6;
   localparam logic [3:0] S_RD_RESP  = 4'd7;
   localparam logic [3:0] S_STOP     = 4'd8;
   localparam logic [3:0] S_END      = 4'd9;

   localparam logic [1:0] PH_SETUP = 2'd0;
   localparam logic [1:0] PH_TRIG  = 2'd1;
   localparam logic [1:0] PH_WAIT  = 2'd2;

   localparam int                 DEPTH    = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0]   PTR_ZERO = {(FIFO_AW+1){1'b0}};
   localparam logic [FIFO_AW:0]   PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0]   REM_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0]   REM_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   logic [3:0]       state_r, nxt_s;
   logic [1:0]       phase_r;
   logic [6:0]       addr_r;
   logic             rw_r, no_stop_r;
   logic [LEN_W-1:0] rem_r;
   logic [3:0]       cmd_r, cmd_s;
   logic [7:0]       data_r, data_s;
   logic             trig_r, busy_r, done_r, nack_r, al_r, held_r;
   logic             issue_ok_s, set_nack_s, dec_rem_s, last_s;
   logic             abort_s, tmo_s;

   logic [7:0]       tx_mem_r [DEPTH];
   logic [7:0]       rx_mem_r [DEPTH];
   logic [FIFO_AW:0] tx_wptr_r, tx_rptr_r, rx_wptr_r, rx_rptr_r;
   logic             tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;
   logic             tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;

   assign tx_empty_s = (tx_wptr_r == tx_rptr_r);
   assign tx_full_s  = (tx_wptr_r[FIFO_AW] != tx_rptr_r[FIFO_AW]) &&
                       (tx_wptr_r[FIFO_AW-1:0] == tx_rptr_r[FIFO_AW-1:0]);
   assign rx_empty_s = (rx_wptr_r == rx_rptr_r);
   assign rx_full_s  = (rx_wptr_r[FIFO_AW] != rx_rptr_r[FIFO_AW]) &&
                       (rx_wptr_r[FIFO_AW-1:0] == rx_rptr_r[FIFO_AW-1:0]);

   assign last_s    = (rem_r == REM_ONE);
   assign abort_s   = (state_r != S_IDLE) && (i_i2c_al || tmo_s);
   assign tx_push_s = i_tx_wr && !tx_full_s;
   assign rx_pop_s  = i_rx_rd && !rx_empty_s;
   assign tx_pop_s  = i_enable && !abort_s && (state_r == S_WR) && (phase_r == PH_SETUP) && !tx_empty_s;
   assign rx_push_s = i_enable && !abort_s && (state_r == S_RD) && (phase_r == PH_WAIT) &&
                      i_cmd_ack && !rx_full_s;

`ifdef I2C_SEQ_TIMEOUT_EN
   localparam int               TMO_W    = $clog2(TMO_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
   localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
   logic [TMO_W-1:0] tmo_cnt_r;
   logic             tmo_wait_s;

   assign tmo_wait_s = (phase_r == PH_WAIT) ||
                       ((state_r == S_WR) && (phase_r == PH_SETUP) && tx_empty_s);
   assign tmo_s      = tmo_wait_s && (tmo_cnt_r == TMO_LAST);

   // Watchdog: counts wait cycles, restarts whenever a command is issued
   always_ff @(posedge i_sysclk or negedge i_nReset) begin
      if (!i_nReset) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else if (!i_enable || !tmo_wait_s || tmo_s) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else begin
         tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
      end
   end
`else
   assign tmo_s = 1'b0 & (TMO_CYC > 0);
`endif

   // Command decode for the current state and its successor on ack
   always_comb begin
      cmd_s      = CMD_IDLE;
      data_s     = 8'h00;
      issue_ok_s = 1'b1;
      nxt_s      = S_IDLE;
      set_nack_s = 1'b0;
      dec_rem_s  = 1'b0;
      case (state_r)
         S_START: begin
            cmd_s = held_r ? CMD_RESTART : CMD_START;
            nxt_s = S_ADDR;
         end
         S_ADDR: begin
            cmd_s  = CMD_WRITE;
            data_s = {addr_r, rw_r};
            nxt_s  = S_ADDR_CHK;
         end
         S_ADDR_CHK: begin
            cmd_s = CMD_RD_ACK;
            if (i_i2c_ack) begin
               set_nack_s = 1'b1;
               nxt_s      = S_STOP;
            end else if (rem_r == REM_ZERO) begin
               nxt_s = S_STOP;
            end else begin
               nxt_s = rw_r ? S_RD : S_WR;
            end
         end
         S_WR: begin
            cmd_s      = CMD_WRITE;
            data_s     = tx_mem_r[tx_rptr_r[FIFO_AW-1:0]];
            issue_ok_s = !tx_empty_s;
            nxt_s      = S_WR_CHK;
         end
         S_WR_CHK: begin
            cmd_s     = CMD_RD_ACK;
            dec_rem_s = 1'b1;
            if (last_s) begin
               nxt_s = S_STOP;
            end else if (i_i2c_ack) begin
               set_nack_s = 1'b1;
               nxt_s      = S_STOP;
            end else begin
               nxt_s = S_WR;
            end
         end
         S_RD: begin
            cmd_s      = CMD_READ;
            issue_ok_s = !rx_full_s;
            nxt_s      = S_RD_RESP;
         end
         S_RD_RESP: begin
            cmd_s     = last_s ? CMD_WR_NAK : CMD_WR_ACK;
            dec_rem_s = 1'b1;
            nxt_s     = last_s ? S_STOP : S_RD;
         end
         S_STOP: begin
            cmd_s = CMD_STOP;
            nxt_s = S_END;
         end
         default: begin
            issue_ok_s = 1'b0;
            nxt_s      = S_IDLE;
         end
      endcase
   end

   // Sequencer: setup -> trigger -> wait-for-ack per command, plus status flags
   always_ff @(posedge i_sysclk or negedge i_nReset) begin
      if (!i_nReset) begin
         state_r   <= S_IDLE;
         phase_r   <= PH_SETUP;
         addr_r    <= 7'h00;
         rw_r      <= 1'b0;
         no_stop_r <= 1'b0;
         rem_r     <= REM_ZERO;
         cmd_r     <= CMD_IDLE;
         data_r    <= 8'h00;
         trig_r    <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         nack_r    <= 1'b0;
         al_r      <= 1'b0;
         held_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         trig_r <= 1'b0;
         if (!i_enable) begin
            state_r <= S_IDLE;
            phase_r <= PH_SETUP;
            cmd_r   <= CMD_IDLE;
            busy_r  <= 1'b0;
            held_r  <= 1'b0;
         end else if (abort_s) begin
            state_r <= S_END;
            phase_r <= PH_SETUP;
            cmd_r   <= CMD_IDLE;
            al_r    <= 1'b1;
            held_r  <= 1'b0;
         end else begin
            case (state_r)
               S_IDLE: begin
                  if (i_go) begin
                     nack_r <= 1'b0;
                     // Bus owned by another master: refuse without touching it
                     if (i_i2c_busy && !held_r) begin
                        al_r   <= 1'b1;
                        done_r <= 1'b1;
                     end else begin
                        al_r      <= 1'b0;
                        addr_r    <= i_slave_addr;
                        rw_r      <= i_rw;
                        rem_r     <= i_len;
                        no_stop_r <= i_no_stop;
                        busy_r    <= 1'b1;
                        state_r   <= S_START;
                     end
                  end
               end
               S_END: begin
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  state_r <= S_IDLE;
               end
               default: begin
                  case (phase_r)
                     PH_SETUP: begin
                        if ((state_r == S_STOP) && no_stop_r && !nack_r) begin
                           held_r  <= 1'b1;
                           state_r <= S_END;
                        end else if (issue_ok_s) begin
                           cmd_r   <= cmd_s;
                           data_r  <= data_s;
                           phase_r <= PH_TRIG;
                        end
                     end
                     PH_TRIG: begin
                        trig_r  <= 1'b1;
                        phase_r <= PH_WAIT;
                     end
                     PH_WAIT: begin
                        if (i_cmd_ack) begin
                           cmd_r   <= CMD_IDLE;
                           phase_r <= PH_SETUP;
                           state_r <= nxt_s;
                           if (set_nack_s) begin
                              nack_r <= 1'b1;
                           end
                           if (dec_rem_s) begin
                              rem_r <= rem_r - REM_ONE;
                           end
                           if (state_r == S_STOP) begin
                              held_r <= 1'b0;
                           end
                        end
                     end
                     default: phase_r <= PH_SETUP;
                  endcase
               end
            endcase
         end
      end
   end

   // TX FIFO storage and pointers; disabling the block flushes it
   always_ff @(posedge i_sysclk or negedge i_nReset) begin
      if (!i_nReset) begin
         tx_wptr_r <= PTR_ZERO;
         tx_rptr_r <= PTR_ZERO;
         for (int i = 0; i < DEPTH; i++) tx_mem_r[i] <= 8'h00;
      end else if (!i_enable) begin
         tx_wptr_r <= PTR_ZERO;
         tx_rptr_r <= PTR_ZERO;
      end else begin
         if (tx_push_s) begin
            tx_mem_r[tx_wptr_r[FIFO_AW-1:0]] <= i_tx_data;
            tx_wptr_r <= tx_wptr_r + PTR_ONE;
         end
         if (tx_pop_s) begin
            tx_rptr_r <= tx_rptr_r + PTR_ONE;
         end
      end
   end

   // RX FIFO storage and pointers; disabling the block flushes it
   always_ff @(posedge i_sysclk or negedge i_nReset) begin
      if (!i_nReset) begin
         rx_wptr_r <= PTR_ZERO;
         rx_rptr_r <= PTR_ZERO;
         for (int i = 0; i < DEPTH; i++) rx_mem_r[i] <= 8'h00;
      end else if (!i_enable) begin
         rx_wptr_r <= PTR_ZERO;
         rx_rptr_r <= PTR_ZERO;
      end else begin
         if (rx_push_s) begin
            rx_mem_r[rx_wptr_r[FIFO_AW-1:0]] <= i_data;
            rx_wptr_r <= rx_wptr_r + PTR_ONE;
         end
         if (rx_pop_s) begin
            rx_rptr_r <= rx_rptr_r + PTR_ONE;
         end
      end
   end

   assign o_tx_full  = tx_full_s;
   assign o_rx_empty = rx_empty_s;
   assign o_rx_data  = rx_mem_r[rx_rptr_r[FIFO_AW-1:0]];
   assign o_cmd_trig = trig_r;
   assign o_cmd      = cmd_r;
   assign o_data     = data_r;
   assign o_busy     = busy_r;
   assign o_done     = done_r;
   assign o_nack     = nack_r;
   assign o_al       = al_r;
   assign o_held     = held_r;
endmodule

// File: tb/tb_i2c_master_xfer_seq.sv
// Table-driven bench for i2c_master_xfer_seq with a scripted byte-controller responder.
module tb_i2c_master_xfer_seq;
   localparam logic [3:0] CMD_IDLE    = 4'h0;
   localparam logic [3:0] CMD_START   = 4'h1;
   localparam logic [3:0] CMD_RESTART = 4'h2;
   localparam logic [3:0] CMD_STOP    = 4'h3;
   localparam logic [3:0] CMD_WRITE   = 4'h4;
   localparam logic [3:0] CMD_READ    = 4'h5;
   localparam logic [3:0] CMD_RD_ACK  = 4'h6;
   localparam logic [3:0] CMD_WR_ACK  = 4'h7;
   localparam logic [3:0] CMD_WR_NAK  = 4'h8;
`ifdef I2C_SEQ_TIMEOUT_EN
   localparam int TMO = 100;
`else
   localparam int TMO = 65535;
`endif

   logic       i_sysclk, i_nReset, i_enable, i_go, i_rw, i_no_stop, i_tx_wr, i_rx_rd;
   logic [6:0] i_slave_addr;
   logic [7:0] i_len, i_tx_data, i_data, o_rx_data, o_data;
   logic       o_tx_full, o_rx_empty, o_cmd_trig, i_cmd_ack, i_i2c_ack, i_i2c_al, i_i2c_busy;
   logic [3:0] o_cmd;
   logic       o_busy, o_done, o_nack, o_al, o_held;

   i2c_master_xfer_seq #(.FIFO_AW(3), .LEN_W(8), .TMO_CYC(TMO)) dut (
      .i_sysclk(i_sysclk), .i_nReset(i_nReset), .i_enable(i_enable), .i_go(i_go),
      .i_slave_addr(i_slave_addr), .i_rw(i_rw), .i_len(i_len), .i_no_stop(i_no_stop),
      .i_tx_wr(i_tx_wr), .i_tx_data(i_tx_data), .o_tx_full(o_tx_full),
      .i_rx_rd(i_rx_rd), .o_rx_data(o_rx_data), .o_rx_empty(o_rx_empty),
      .o_cmd_trig(o_cmd_trig), .o_cmd(o_cmd), .o_data(o_data), .i_cmd_ack(i_cmd_ack),
      .i_i2c_ack(i_i2c_ack), .i_i2c_al(i_i2c_al), .i_i2c_busy(i_i2c_busy), .i_data(i_data),
      .o_busy(o_busy), .o_done(o_done), .o_nack(o_nack), .o_al(o_al), .o_held(o_held)
   );

   initial begin
      i_sysclk = 1'b0;
      forever #5 i_sysclk = ~i_sysclk;
   end

   typedef struct {
      logic [6:0]        addr;
      logic              rw;
      logic [7:0]        len;
      int                ntx;
      logic [2:0][7:0]   tx;
      int                nrx;
      logic [2:0][7:0]   rx;
      int                nack_idx;
      logic              exp_nack;
      int                nseq;
      logic [9:0][11:0]  seq;
   } vec_t;

   localparam int NV = 6;
   vec_t vecs [NV];

   int n_cmp = 0;
   int n_bad = 0;
   logic [3:0] got_cmd [16];
   logic [7:0] got_dat [16];
   int got_n, nack_idx, al_at, al_cyc, done_cyc;
   logic [7:0] rd_q [$];
   logic [9:0][11:0] hs;
   int hn;
   bit ds;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic hclr();
      hs = '0;
      hn = 0;
   endtask

   task automatic hx(input logic [3:0] c, input logic [7:0] d);
      hs[hn] = {c, d};
      hn++;
   endtask

   function automatic vec_t mk(input logic [6:0] a, input logic rw, input logic [7:0] len,
                               input int ntx, input logic [23:0] tx, input int nrx,
                               input logic [23:0] rx, input int nidx, input logic en);
      vec_t v;
      v.addr = a; v.rw = rw; v.len = len; v.ntx = ntx; v.tx = tx; v.nrx = nrx; v.rx = rx;
      v.nack_idx = nidx; v.exp_nack = en; v.nseq = 0; v.seq = '0;
      return v;
   endfunction

   task automatic cmp_seq(input string tag, input int n, input logic [9:0][11:0] seq);
      check({tag, "_ncmd"}, got_n, n);
      for (int i = 0; i < n && i < got_n; i++) begin
         check($sformatf("%s_cmd%0d", tag, i), {28'h0, got_cmd[i]}, {28'h0, seq[i][11:8]});
         if (seq[i][11:8] == CMD_WRITE)
            check($sformatf("%s_data%0d", tag, i), {24'h0, got_dat[i]}, {24'h0, seq[i][7:0]});
      end
   endtask

   // Responds to each trigger two cycles later with ack (or arbitration loss)
   task automatic serve(input int budget, output bit done_seen);
      int pend, wc, n_rdack;
      logic [3:0] prev_cmd;
      done_seen = 1'b0; got_n = 0; pend = 0; wc = 0; n_rdack = 0; prev_cmd = CMD_IDLE;
      for (int c = 0; c < budget && !done_seen; c++) begin
         @(negedge i_sysclk);
         i_cmd_ack = 1'b0; i_i2c_al = 1'b0; i_i2c_ack = 1'b0;
         if (o_done) begin
            done_seen = 1'b1;
            done_cyc  = c;
         end
         if (o_cmd_trig) begin
            check("cmd_setup", {28'h0, prev_cmd}, {28'h0, o_cmd});
            if (got_n < 16) begin
               got_cmd[got_n] = o_cmd;
               got_dat[got_n] = o_data;
               got_n++;
            end
            pend = 1; wc = 2;
         end else if (pend != 0) begin
            wc--;
            if (wc == 0) begin
               pend = 0;
               if (got_n - 1 == al_at) begin
                  i_i2c_al = 1'b1;
                  al_cyc   = c;
               end else begin
                  i_cmd_ack = 1'b1;
                  if (got_cmd[got_n-1] == CMD_RD_ACK) begin
                     i_i2c_ack = (n_rdack == nack_idx);
                     n_rdack++;
                  end
                  if (got_cmd[got_n-1] == CMD_READ && rd_q.size() > 0) i_data = rd_q.pop_front();
               end
            end
         end
         prev_cmd = o_cmd;
      end
      @(negedge i_sysclk);
      i_cmd_ack = 1'b0; i_i2c_al = 1'b0; i_i2c_ack = 1'b0;
   endtask

   task automatic flush();
      @(negedge i_sysclk); i_enable = 1'b0;
      @(negedge i_sysclk); i_enable = 1'b1;
   endtask

   task automatic push(input logic [7:0] b);
      @(negedge i_sysclk); i_tx_wr = 1'b1; i_tx_data = b;
      @(negedge i_sysclk); i_tx_wr = 1'b0;
   endtask

   task automatic go(input logic [6:0] a, input logic rw, input logic [7:0] len, input logic ns);
      @(negedge i_sysclk);
      i_slave_addr = a; i_rw = rw; i_len = len; i_no_stop = ns; i_go = 1'b1;
      @(negedge i_sysclk);
      i_go = 1'b0;
   endtask

   task automatic pop_chk(input string tag, input logic [7:0] b);
      check(tag, {24'h0, o_rx_data}, {24'h0, b});
      i_rx_rd = 1'b1;
      @(negedge i_sysclk);
      i_rx_rd = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      i_nReset = 1'b0; i_enable = 1'b1; i_go = 1'b0; i_rw = 1'b0; i_no_stop = 1'b0;
      i_tx_wr = 1'b0; i_rx_rd = 1'b0; i_slave_addr = 7'h00; i_len = 8'h00; i_tx_data = 8'h00;
      i_data = 8'h00; i_cmd_ack = 1'b0; i_i2c_ack = 1'b0; i_i2c_al = 1'b0; i_i2c_busy = 1'b0;
      nack_idx = -1; al_at = -1; al_cyc = 0; done_cyc = 0;

      vecs[0] = mk(7'h50, 1'b0, 8'd2, 2, {8'h00, 8'h3C, 8'hA5}, 0, 24'h0, -1, 1'b0);
      hclr(); hx(CMD_START, 8'h00); hx(CMD_WRITE, 8'hA0); hx(CMD_RD_ACK, 8'h00);
      hx(CMD_WRITE, 8'hA5); hx(CMD_RD_ACK, 8'h00); hx(CMD_WRITE, 8'h3C); hx(CMD_RD_ACK, 8'h00);
      hx(CMD_STOP, 8'h00); vecs[0].seq = hs; vecs[0].nseq = hn;
      vecs[1] = mk(7'h51, 1'b1, 8'd3, 0, 24'h0, 3, {8'h33, 8'h22, 8'h11}, -1, 1'b0);
      hclr(); hx(CMD_START, 8'h00); hx(CMD_WRITE, 8'hA3); hx(CMD_RD_ACK, 8'h00);
      hx(CMD_READ, 8'h00); hx(CMD_WR_ACK, 8'h00); hx(CMD_READ, 8'h00); hx(CMD_WR_ACK, 8'h00);
      hx(CMD_READ, 8'h00); hx(CMD_WR_NAK, 8'h00); hx(CMD_STOP, 8'h00);
      vecs[1].seq = hs; vecs[1].nseq = hn;
      vecs[2] = mk(7'h7F, 1'b0, 8'd2, 0, 24'h0, 0, 24'h0, 0, 1'b1);
      hclr(); hx(CMD_START, 8'h00); hx(CMD_WRITE, 8'hFE); hx(CMD_RD_ACK, 8'h00); hx(CMD_STOP, 8'h00);
      vecs[2].seq = hs; vecs[2].nseq = hn;
      vecs[3] = mk(7'h20, 1'b0, 8'd1, 1, {16'h0, 8'h5A}, 0, 24'h0, 1, 1'b0);
      hclr(); hx(CMD_START, 8'h00); hx(CMD_WRITE, 8'h40); hx(CMD_RD_ACK, 8'h00);
      hx(CMD_WRITE, 8'h5A); hx(CMD_RD_ACK, 8'h00); hx(CMD_STOP, 8'h00);
      vecs[3].seq = hs; vecs[3].nseq = hn;
      vecs[4] = mk(7'h20, 1'b0, 8'd2, 2, {8'h00, 8'h02, 8'h01}, 0, 24'h0, 1, 1'b1);
      hclr(); hx(CMD_START, 8'h00); hx(CMD_WRITE, 8'h40); hx(CMD_RD_ACK, 8'h00);
      hx(CMD_WRITE, 8'h01); hx(CMD_RD_ACK, 8'h00); hx(CMD_STOP, 8'h00);
      vecs[4].seq = hs; vecs[4].nseq = hn;
      vecs[5] = mk(7'h33, 1'b1, 8'd0, 0, 24'h0, 0, 24'h0, -1, 1'b0);
      hclr(); hx(CMD_START, 8'h00); hx(CMD_WRITE, 8'h67); hx(CMD_RD_ACK, 8'h00); hx(CMD_STOP, 8'h00);
      vecs[5].seq = hs; vecs[5].nseq = hn;

      repeat (3) @(negedge i_sysclk);
      check("rst_cmd", {28'h0, o_cmd}, {28'h0, CMD_IDLE});
      check("rst_rx_empty", {31'h0, o_rx_empty}, 32'd1);
      check("rst_flags", {24'h0, o_busy, o_done, o_nack, o_al, o_held, o_cmd_trig, o_tx_full, 1'b0}, 32'd0);
      check("rst_data", {16'h0, o_data, o_rx_data}, 32'd0);
      i_nReset = 1'b1;

      for (int v = 0; v < NV; v++) begin
         flush();
         for (int i = 0; i < vecs[v].ntx; i++) push(vecs[v].tx[i]);
         rd_q.delete();
         for (int i = 0; i < vecs[v].nrx; i++) rd_q.push_back(vecs[v].rx[i]);
         nack_idx = vecs[v].nack_idx; al_at = -1;
         go(vecs[v].addr, vecs[v].rw, vecs[v].len, 1'b0);
         check($sformatf("v%0d_busy", v), {31'h0, o_busy}, 32'd1);
         serve(200, ds);
         check($sformatf("v%0d_done", v), {31'h0, ds}, 32'd1);
         cmp_seq($sformatf("v%0d", v), vecs[v].nseq, vecs[v].seq);
         check($sformatf("v%0d_nack", v), {31'h0, o_nack}, {31'h0, vecs[v].exp_nack});
         check($sformatf("v%0d_end", v), {29'h0, o_busy, o_held, o_al}, 32'd0);
         for (int i = 0; i < vecs[v].nrx; i++) pop_chk($sformatf("v%0d_rx%0d", v, i), vecs[v].rx[i]);
         check($sformatf("v%0d_rx_empty", v), {31'h0, o_rx_empty}, 32'd1);
      end

      // Repeated START: held write, then read beginning with RESTART
      flush(); push(8'h77); nack_idx = -1; al_at = -1;
      go(7'h10, 1'b0, 8'd1, 1'b1);
      serve(200, ds);
      hclr(); hx(CMD_START, 8'h00); hx(CMD_WRITE, 8'h20); hx(CMD_RD_ACK, 8'h00);
      hx(CMD_WRITE, 8'h77); hx(CMD_RD_ACK, 8'h00);
      check("rs1_done", {31'h0, ds}, 32'd1);
      cmp_seq("rs1", hn, hs);
      check("rs1_held", {31'h0, o_held}, 32'd1);
      i_i2c_busy = 1'b1; rd_q.delete(); rd_q.push_back(8'h9C);
      go(7'h10, 1'b1, 8'd1, 1'b0);
      serve(200, ds);
      hclr(); hx(CMD_RESTART, 8'h00); hx(CMD_WRITE, 8'h21); hx(CMD_RD_ACK, 8'h00);
      hx(CMD_READ, 8'h00); hx(CMD_WR_NAK, 8'h00); hx(CMD_STOP, 8'h00);
      check("rs2_done", {31'h0, ds}, 32'd1);
      cmp_seq("rs2", hn, hs);
      check("rs2_held", {31'h0, o_held}, 32'd0);
      pop_chk("rs2_rx", 8'h9C);

      // Busy bus without hold: refused in the same cycle
      go(7'h10, 1'b0, 8'd1, 1'b0);
      check("refuse", {29'h0, o_done, o_al, o_busy}, 32'b110);
      i_i2c_busy = 1'b0;

      // Arbitration lost during the second WRITE
      flush(); push(8'hA5); push(8'h3C); al_at = 3;
      go(7'h50, 1'b0, 8'd2, 1'b0);
      serve(200, ds);
      hclr(); hx(CMD_START, 8'h00); hx(CMD_WRITE, 8'hA0); hx(CMD_RD_ACK, 8'h00); hx(CMD_WRITE, 8'hA5);
      check("al_done", {31'h0, ds}, 32'd1);
      cmp_seq("al", hn, hs);
      check("al_flags", {30'h0, o_al, o_busy}, 32'b10);
      check("al_latency", {31'h0, (done_cyc - al_cyc) <= 2}, 32'd1);
      al_at = -1;

      // TX FIFO fill to full; overflow push ignored
      flush();
      for (int i = 0; i < 9; i++) push(8'(i));
      check("tx_full", {31'h0, o_tx_full}, 32'd1);
      flush();
      check("tx_flushed", {31'h0, o_tx_full}, 32'd0);

      // TX underrun stall
      push(8'h11);
      go(7'h50, 1'b0, 8'd2, 1'b0);
      serve(60, ds);
      hclr(); hx(CMD_START, 8'h00); hx(CMD_WRITE, 8'hA0); hx(CMD_RD_ACK, 8'h00);
      hx(CMD_WRITE, 8'h11); hx(CMD_RD_ACK, 8'h00);
      check("stall_nodone", {31'h0, ds}, 32'd0);
      cmp_seq("stall", hn, hs);
      check("stall_busy", {31'h0, o_busy}, 32'd1);
`ifdef I2C_SEQ_TIMEOUT_EN
      ds = 1'b0;
      for (int c = 0; c < 200 && !ds; c++) begin
         @(negedge i_sysclk);
         if (o_done) ds = 1'b1;
      end
      check("tmo_done", {31'h0, ds}, 32'd1);
      check("tmo_al", {31'h0, o_al}, 32'd1);
`endif
      flush();
      check("stall_abort", {31'h0, o_busy}, 32'd0);

      // Abort with a command outstanding
      go(7'h33, 1'b1, 8'd0, 1'b0);
      ds = 1'b0;
      for (int c = 0; c < 20 && !ds; c++) begin
         @(negedge i_sysclk);
         if (o_cmd_trig) ds = 1'b1;
      end
      check("abort_trig", {31'h0, ds}, 32'd1);
      check("abort_pre_cmd", {28'h0, o_cmd}, {28'h0, CMD_START});
      i_enable = 1'b0;
      @(negedge i_sysclk);
      check("abort_cmd", {28'h0, o_cmd}, {28'h0, CMD_IDLE});
      check("abort_busy", {31'h0, o_busy}, 32'd0);
      i_enable = 1'b1;
      repeat (5) @(negedge i_sysclk);
      check("abort_quiet", {30'h0, o_cmd_trig, o_busy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/i2c_master_xfer_seq.md
Name: i2c_master_xfer_seq

Overview:
- Transaction sequencer that sits directly upstream of the I2C byte-level controller.
- Accepts one transfer descriptor (7-bit slave address, direction, byte count, stop/hold).
- Issues the ordered byte commands (START, WRITE, RD_ACK, READ, WR_ACK/WR_NAK, STOP) over the trigger/ack handshake.
- Buffers TX bytes in a small FIFO and RX bytes in a second FIFO for the register/CPU side.

Parameters:
- FIFO_AW, 3, log2 of TX and RX FIFO depth (depth 8).
- LEN_W, 8, width of the byte-count field. Maximum transfer is 2^LEN_W-1 bytes.
- TMO_CYC, 65535, watchdog limit in i_sysclk cycles per command (used only with the optional feature).

Ports:
- i_sysclk  in  1  system clock
- i_nReset  in  1  asynchronous active-low reset
- i_enable  in  1  block enable; low aborts and holds the sequencer in IDLE
- i_go  in  1  one-cycle start pulse; samples the descriptor
- i_slave_addr  in  7  target address
- i_rw  in  1  0=write, 1=read
- i_len  in  LEN_W  number of data bytes; 0 means address-only probe
- i_no_stop  in  1  1=end without STOP, leaving the bus held for a repeated START
- i_tx_wr  in  1  push i_tx_data into the TX FIFO
- i_tx_data  in  8  TX byte
- o_tx_full  out  1  TX FIFO full
- i_rx_rd  in  1  pop from the RX FIFO
- o_rx_data  out  8  RX FIFO head (first-word fall-through)
- o_rx_empty  out  1  RX FIFO empty
- o_cmd_trig  out  1  command strobe to the byte controller
- o_cmd  out  4  CMD_* code from the shared I2C definitions header
- o_data  out  8  byte presented with CMD_WRITE
- i_cmd_ack  in  1  byte controller command complete (one-cycle pulse)
- i_i2c_ack  in  1  slave ACK bit sampled by CMD_RD_ACK; 0=ACK
- i_i2c_al  in  1  arbitration lost
- i_i2c_busy  in  1  bus busy
- i_data  in  8  byte received by CMD_READ
- o_busy  out  1  transfer in progress
- o_done  out  1  one-cycle pulse at transfer end, including error ends
- o_nack  out  1  sticky: slave NACKed; cleared by i_go
- o_al  out  1  sticky: arbitration lost; cleared by i_go
- o_held  out  1  bus held after an i_no_stop transfer

Behaviour:
- Reset values:
  - all outputs 0, except o_rx_empty=1 and o_cmd=CMD_IDLE.
  - FIFOs empty; state IDLE.
- Command handshake:
  - o_cmd/o_data are driven 1 cycle before o_cmd_trig rises.
  - o_cmd_trig is high for exactly 1 cycle.
  - o_cmd/o_data are held stable until i_cmd_ack.
  - Exactly one command is outstanding at a time.
- States: IDLE, START, ADDR, ADDR_CHK, WR, WR_CHK, RD, RD_RESP, STOP, END.
- IDLE:
  - i_go with i_enable is accepted.
  - If i_i2c_busy=1 and o_held=0, the transfer is refused: o_done and o_al pulse/set in the same cycle.
  - Otherwise latch the descriptor, set o_busy, and go to START.
  - When o_held=1, CMD_RESTART is issued instead of CMD_START.
- START: issue START/RESTART, then go to ADDR on ack.
- ADDR: issue CMD_WRITE with o_data={addr,rw}.
- ADDR_CHK: issue CMD_RD_ACK.
  - i_i2c_ack=1: set o_nack, go to STOP.
  - len=0: go to STOP.
  - Otherwise go to WR or RD.
- WR:
  - If the TX FIFO is empty, wait (no timeout unless the optional feature is compiled in).
  - Pop the byte, issue CMD_WRITE, then go to WR_CHK.
- WR_CHK: issue CMD_RD_ACK.
  - NACK before the last byte: set o_nack, go to STOP.
  - Last byte ACK or NACK: go to STOP (o_nack not set).
- RD:
  - Wait while the RX FIFO is full.
  - Issue CMD_READ; push i_data on ack.
- RD_RESP:
  - Issue CMD_WR_ACK if bytes remain, CMD_WR_NAK on the last byte.
  - Decrement the remaining count.
- STOP:
  - If i_no_stop=1 and there is no error: skip STOP and set o_held.
  - Otherwise issue CMD_STOP and clear o_held.
- END: pulse o_done, clear o_busy, return to IDLE.
- i_i2c_al=1 in any non-IDLE state:
  - Set o_al, drop the outstanding command, clear o_held.
  - Go to END with no STOP issued.
- i_enable=0:
  - Synchronously force IDLE and o_cmd=CMD_IDLE; o_busy=0.
  - FIFOs are flushed; sticky flags are kept.
- i_go while o_busy: ignored.
- FIFOs:
  - Pointers are FIFO_AW+1 bits; full/empty come from MSB compare.
  - Push when full and pop when empty are ignored.
  - Simultaneous push and pop are allowed.

Optional Feature:
- Macro: I2C_SEQ_TIMEOUT_EN.
- Defined:
  - A counter runs while waiting for i_cmd_ack or for TX data.
  - Reaching TMO_CYC sets o_al, drops the command, and goes to END.
  - The counter restarts on every issued command.
- Undefined:
  - No counter; waits are unbounded.

Test Plan:
- Write: addr 0x50, rw=0, len=2, TX 0xA5,0x3C, all ACK → command sequence START, WRITE 0xA0, RD_ACK, WRITE 0xA5, RD_ACK, WRITE 0x3C, RD_ACK, STOP; then o_done pulse, o_nack=0.
- Read: addr 0x51, len=3, bytes 0x11,0x22,0x33 → RD_ACK after the address; READ/WR_ACK twice, then READ/WR_NAK, then STOP; RX pops 0x11,0x22,0x33.
- Address NACK: addr 0x7F, i_i2c_ack=1 at ADDR_CHK → o_nack=1, STOP issued, no data commands.
- Repeated START: write len=1 with i_no_stop=1 → o_held=1, no STOP; then a read go → CMD_RESTART issued first; final STOP clears o_held.
- Arbitration: i_i2c_al pulses during the second WRITE → o_al=1, o_done pulses within 2 cycles, no STOP issued, o_busy=0.
- TX empty and abort: write len=2 with only 1 byte loaded → sequencer stalls in WR; i_enable=0 → IDLE and o_cmd=CMD_IDLE; with I2C_SEQ_TIMEOUT_EN and TMO_CYC=100, o_al is set after 100 cycles.
